// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the three-way cache port arbiter.
package cache_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam logic [1:0] REQ_A    = 2'd0;
    localparam logic [1:0] REQ_B    = 2'd1;
    localparam logic [1:0] REQ_C    = 2'd2;
    localparam logic [1:0] REQ_NONE = 2'd3;

    // Mod-3 increment; an illegal id of 3 folds back to A.
    function automatic logic [1:0] next_req(input logic [1:0] id);
        case (id)
            REQ_A:   next_req = REQ_B;
            REQ_B:   next_req = REQ_C;
            default: next_req = REQ_A;
        endcase
    endfunction

    // Strobe bit of requester id; id 3 selects nothing.
    function automatic logic sel3(input logic [2:0] vec, input logic [1:0] id);
        case (id)
            REQ_A:   sel3 = vec[0];
            REQ_B:   sel3 = vec[1];
            REQ_C:   sel3 = vec[2];
            default: sel3 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational rotating-priority picker over three strobes.
module rr_pick3
    import cache_arb_pkg::*;
(
    input  logic [2:0] strobe,
    input  logic [1:0] prio,
    output logic       found,
    output logic [1:0] winner
);

    logic [1:0] idx;

    // Scan prio, prio+1, prio+2; a faulty prio of 3 starts the scan at A.
    always_comb begin
        found  = 1'b0;
        winner = REQ_NONE;
        idx    = (prio == REQ_NONE) ? REQ_A : prio;
        for (int i = 0; i < 3; i++) begin
            if (!found && sel3(strobe, idx)) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = next_req(idx);
        end
    end

endmodule

// File: rtl/cache_arb_rr3.sv
// Round-robin arbiter sharing one cache port among requesters A, B and C,
// with zero-latency pass-through on hits and lock-on-miss.
module cache_arb_rr3
    import cache_arb_pkg::*;
#(
    parameter int unsigned IDLE_ADDR_SEL = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] cache_a_address,
    input  logic        cache_a_strobe,
    input  logic [3:0]  cache_a_request,
    input  logic [1:0]  cache_a_size,
    input  logic [31:0] cache_a_wdata,
    output logic        cache_a_valid,

    input  logic [31:0] cache_b_address,
    input  logic        cache_b_strobe,
    input  logic [3:0]  cache_b_request,
    input  logic [1:0]  cache_b_size,
    input  logic [31:0] cache_b_wdata,
    output logic        cache_b_valid,

    input  logic [31:0] cache_c_address,
    input  logic        cache_c_strobe,
    input  logic [3:0]  cache_c_request,
    input  logic [1:0]  cache_c_size,
    input  logic [31:0] cache_c_wdata,
    output logic        cache_c_valid,

    output logic [31:0] cache_address,
    output logic        cache_strobe,
    output logic [3:0]  cache_request,
    output logic [1:0]  cache_size,
    output logic [31:0] cache_wdata,
    input  logic        cache_valid,

    output logic [1:0]  arb_owner,
    output logic        arb_locked
);

    localparam logic [1:0] IDLE_SEL = 2'(IDLE_ADDR_SEL);

    arb_state_t state, state_nx;
    logic [1:0] owner, owner_nx;
    logic [1:0] prio, prio_nx;
    logic [2:0] strobe_vec;
    logic       pick_found;
    logic [1:0] pick_winner;
    logic [1:0] cur_sel;
    logic       active;

    assign strobe_vec = {cache_c_strobe, cache_b_strobe, cache_a_strobe};

    rr_pick3 u_pick (
        .strobe (strobe_vec),
        .prio   (prio),
        .found  (pick_found),
        .winner (pick_winner)
    );

    // Who is muxed: the lock owner, else the idle winner; active means its strobe is live.
    always_comb begin
        cur_sel = REQ_NONE;
        active  = 1'b0;
        if (state == ARB_LOCKED) begin
            cur_sel = owner;
            active  = sel3(strobe_vec, owner);
        end else if (pick_found) begin
            cur_sel = pick_winner;
            active  = 1'b1;
        end
    end

    assign arb_owner  = cur_sel;
    assign arb_locked = (state == ARB_LOCKED);

    // Output mux; with no live strobe the idle address keeps tag lookups warm.
    always_comb begin
        cache_strobe  = 1'b0;
        cache_request = 4'd0;
        cache_size    = 2'd0;
        cache_wdata   = 32'd0;
        cache_a_valid = 1'b0;
        cache_b_valid = 1'b0;
        cache_c_valid = 1'b0;
        case (IDLE_SEL)
            REQ_B:   cache_address = cache_b_address;
            REQ_C:   cache_address = cache_c_address;
            default: cache_address = cache_a_address;
        endcase
        if (active) begin
            cache_strobe = 1'b1;
            case (cur_sel)
                REQ_A: begin
                    cache_address = cache_a_address;
                    cache_request = cache_a_request;
                    cache_size    = cache_a_size;
                    cache_wdata   = cache_a_wdata;
                    cache_a_valid = cache_valid;
                end
                REQ_B: begin
                    cache_address = cache_b_address;
                    cache_request = cache_b_request;
                    cache_size    = cache_b_size;
                    cache_wdata   = cache_b_wdata;
                    cache_b_valid = cache_valid;
                end
                REQ_C: begin
                    cache_address = cache_c_address;
                    cache_request = cache_c_request;
                    cache_size    = cache_c_size;
                    cache_wdata   = cache_c_wdata;
                    cache_c_valid = cache_valid;
                end
                default: cache_strobe = 1'b0;
            endcase
        end
    end

    // Next-state: hits rotate priority in place, misses lock, drops abandon.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        prio_nx  = prio;
        if (state == ARB_IDLE) begin
            if (pick_found) begin
                if (cache_valid) begin
                    prio_nx = next_req(pick_winner);
                end else begin
                    state_nx = ARB_LOCKED;
                    owner_nx = pick_winner;
                end
            end
        end else begin
            if (!active) begin
                state_nx = ARB_IDLE;
                owner_nx = REQ_NONE;
            end else if (cache_valid) begin
                state_nx = ARB_IDLE;
                owner_nx = REQ_NONE;
                prio_nx  = next_req(owner);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
            owner <= REQ_NONE;
            prio  <= REQ_A;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            prio  <= prio_nx;
        end
    end

endmodule
